// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit pipelined core.
//   - opcode_t      : 4-bit opcode encoding (instruction bits [15:12])
//   - id_state_t    : decode-stage control state (RUN / STALL / HALT)
//   - idex_t        : ID/EX pipeline register contents
//   - field LSB constants for the fixed 4-field instruction layout
//   - R_LINK        : link register written by CALL
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ALU1 = 4'h1,
        OP_ALU2 = 4'h2,
        OP_ALU3 = 4'h3,
        OP_ALU4 = 4'h4,
        OP_ALU5 = 4'h5,
        OP_ALU6 = 4'h6,
        OP_ALU7 = 4'h7,
        OP_LW   = 4'h8,
        OP_SW   = 4'h9,
        OP_LHB  = 4'hA,
        OP_LLB  = 4'hB,
        OP_B    = 4'hC,
        OP_CALL = 4'hD,
        OP_RET  = 4'hE,
        OP_HLT  = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } id_state_t;

    // Instruction field positions (each field is 4 bits wide).
    localparam int unsigned OP_LSB = 12;
    localparam int unsigned RD_LSB = 8;
    localparam int unsigned RS_LSB = 4;
    localparam int unsigned RT_LSB = 0;

    localparam logic [3:0] R_LINK = 4'd15;

    typedef struct packed {
        logic        valid;
        logic [15:0] pc;
        logic [3:0]  opcode;
        logic [3:0]  rd;
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [15:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        halt;
    } idex_t;

endpackage

// File: rtl/reg_file.sv
// reg_file: 16x16 register file, two combinational read ports, one write port.
// R0 is hard-wired to zero (writes ignored, reads return 0).
// Ports:
//   clk, rst        : clock, asynchronous active-low reset (clears all entries)
//   we/waddr/wdata  : write port, committed on the rising edge
//   raddr_a/rdata_a : read port A
//   raddr_b/rdata_b : read port B
// Configuration macro WB_BYPASS_EN: when defined, reads are write-first
// (a same-cycle write to the addressed register is forwarded to the read).
module reg_file #(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [3:0]  raddr_a,
    input  logic [3:0]  raddr_b,
    output logic [15:0] rdata_a,
    output logic [15:0] rdata_b
);

    logic [15:0] regs_q [NUM_REGS];
    logic [15:0] regs_d [NUM_REGS];

    function automatic logic [15:0] read_port(input logic [3:0] addr);
        logic [15:0] val;
        val = '0;
        if (addr != '0) begin
            val = regs_q[addr];
`ifdef WB_BYPASS_EN
            if (we && (waddr == addr)) begin
                val = wdata;
            end
`endif
        end
        return val;
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata_a = read_port(raddr_a);
        rdata_b = read_port(raddr_b);
    end

endmodule

// File: rtl/id_unit.sv
// id_unit: instruction-decode stage of the 16-bit pipelined core.
// Holds the IF/ID register, the register file and decode logic, and drives
// the ID/EX register. Produces 'hazard' back to fetch (hold PC and IF/ID)
// for load-use stalls, write-back stalls and halt.
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   instr_in, pc_in         : fetched instruction and its PC+2
//   flush                   : taken branch downstream; squash IF/ID and ID/EX
//   wb_en, wb_addr, wb_data : register write-back port
//   hazard                  : combinational stall request to fetch
//   id_*                    : ID/EX register outputs
// Configuration macro WB_BYPASS_EN: when defined, register reads are
// write-first; when undefined, a write-back to a register that IF/ID is
// reading stalls decode for one cycle instead.
module id_unit
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_in,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [3:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic        hazard,
    output logic        id_valid,
    output logic [15:0] id_pc,
    output logic [3:0]  id_opcode,
    output logic [3:0]  id_rd,
    output logic [15:0] id_rs_data,
    output logic [15:0] id_rt_data,
    output logic [15:0] id_imm,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_branch,
    output logic        id_halt
);

    // IF/ID register
    logic [15:0] ifid_instr_q, ifid_instr_d;
    logic [15:0] ifid_pc_q,    ifid_pc_d;
    logic        ifid_valid_q, ifid_valid_d;

    // ID/EX register
    idex_t idex_q, idex_d;

    id_state_t state_q, state_d;

    // Decode results
    opcode_t     op;
    logic [3:0]  rd_f, rs_f, rt_f;
    logic [3:0]  rs_addr, rt_addr, dst;
    logic        use_rs, use_rt;
    logic [15:0] imm;
    logic        dec_rw, dec_mr, dec_mw, dec_br, dec_hl;
    logic [15:0] rs_data, rt_data;

    // Hazard / stall control
    logic load_use, wb_stall, hazard_int, bubble;

    reg_file #(
        .NUM_REGS (NUM_REGS)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (rs_data),
        .rdata_b (rt_data)
    );

    // ---------------------------------------------------------------- decode
    always_comb begin
        op      = opcode_t'(ifid_instr_q[OP_LSB +: 4]);
        rd_f    = ifid_instr_q[RD_LSB +: 4];
        rs_f    = ifid_instr_q[RS_LSB +: 4];
        rt_f    = ifid_instr_q[RT_LSB +: 4];
        rs_addr = rs_f;
        rt_addr = rt_f;
        dst     = rd_f;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        imm     = '0;
        dec_rw  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_br  = 1'b0;
        dec_hl  = 1'b0;
        case (op)
            OP_LW: begin
                imm    = {{12{ifid_instr_q[3]}}, ifid_instr_q[3:0]};
                use_rs = 1'b1;
                dec_rw = 1'b1;
                dec_mr = 1'b1;
            end
            OP_SW: begin
                // Store data comes from the [11:8] field.
                rt_addr = rd_f;
                imm     = {{12{ifid_instr_q[3]}}, ifid_instr_q[3:0]};
                use_rs  = 1'b1;
                use_rt  = 1'b1;
                dec_mw  = 1'b1;
            end
            OP_LHB, OP_LLB: begin
                // Byte insert reads the destination's current value.
                rs_addr = rd_f;
                imm     = {8'h00, ifid_instr_q[7:0]};
                use_rs  = 1'b1;
                dec_rw  = 1'b1;
            end
            OP_B: begin
                imm    = {{7{ifid_instr_q[8]}}, ifid_instr_q[8:0]};
                dec_br = 1'b1;
            end
            OP_CALL: begin
                dst    = R_LINK;
                imm    = {{4{ifid_instr_q[11]}}, ifid_instr_q[11:0]};
                dec_rw = 1'b1;
                dec_br = 1'b1;
            end
            OP_RET: begin
                dec_br = 1'b1;
            end
            OP_HLT: begin
                dec_hl = 1'b1;
            end
            default: begin
                // ALU operations 0-7
                use_rs = 1'b1;
                use_rt = 1'b1;
                dec_rw = 1'b1;
            end
        endcase
        if (dst == '0) begin
            dec_rw = 1'b0;
        end
    end

    // ------------------------------------------------ FSM: output / hazard
    always_comb begin
        load_use = idex_q.valid && idex_q.mem_read && (idex_q.rd != '0) &&
                   ifid_valid_q &&
                   ((use_rs && (idex_q.rd == rs_addr)) ||
                    (use_rt && (idex_q.rd == rt_addr)));
`ifdef WB_BYPASS_EN
        wb_stall = 1'b0;
`else
        wb_stall = ifid_valid_q && wb_en && (wb_addr != '0) &&
                   ((use_rs && (wb_addr == rs_addr)) ||
                    (use_rt && (wb_addr == rt_addr)));
`endif
        // The flushing branch is older than anything here, so it wins.
        hazard_int = !flush && ((state_q == HALT) || load_use || wb_stall);
        bubble     = flush || hazard_int || !ifid_valid_q;
    end

    assign hazard = hazard_int;

    // ---------------------------------------------------- FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN, STALL: begin
                    if (!bubble && dec_hl) begin
                        state_d = HALT;
                    end else if (load_use) begin
                        state_d = STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = RUN;
            endcase
        end
    end

    // ------------------------------------------------ pipeline next values
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        if (flush) begin
            ifid_instr_d = instr_in;
            ifid_pc_d    = pc_in;
            ifid_valid_d = 1'b0;
        end else if (!hazard_int) begin
            ifid_instr_d = instr_in;
            ifid_pc_d    = pc_in;
            ifid_valid_d = 1'b1;
        end
    end

    always_comb begin
        idex_d = '0;
        if (!bubble) begin
            idex_d.valid     = 1'b1;
            idex_d.pc        = ifid_pc_q;
            idex_d.opcode    = op;
            idex_d.rd        = dst;
            idex_d.rs_data   = rs_data;
            idex_d.rt_data   = rt_data;
            idex_d.imm       = imm;
            idex_d.reg_write = dec_rw;
            idex_d.mem_read  = dec_mr;
            idex_d.mem_write = dec_mw;
            idex_d.branch    = dec_br;
            idex_d.halt      = dec_hl;
        end
    end

    // ----------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            idex_q       <= '0;
        end else begin
            state_q      <= state_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            idex_q       <= idex_d;
        end
    end

    assign id_valid     = idex_q.valid;
    assign id_pc        = idex_q.pc;
    assign id_opcode    = idex_q.opcode;
    assign id_rd        = idex_q.rd;
    assign id_rs_data   = idex_q.rs_data;
    assign id_rt_data   = idex_q.rt_data;
    assign id_imm       = idex_q.imm;
    assign id_reg_write = idex_q.reg_write;
    assign id_mem_read  = idex_q.mem_read;
    assign id_mem_write = idex_q.mem_write;
    assign id_branch    = idex_q.branch;
    assign id_halt      = idex_q.halt;

endmodule

// File: tb/tb_id_unit.sv
module tb_id_unit;

    localparam logic [15:0] FILLER = 16'hC000;  // B with no register sources

    logic        clk;
    logic        rst;
    logic [15:0] instr_in;
    logic [15:0] pc_in;
    logic        flush;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        hazard;
    logic        id_valid;
    logic [15:0] id_pc;
    logic [3:0]  id_opcode;
    logic [3:0]  id_rd;
    logic [15:0] id_rs_data;
    logic [15:0] id_rt_data;
    logic [15:0] id_imm;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_branch;
    logic        id_halt;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    id_unit #(
        .NUM_REGS (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_in     (instr_in),
        .pc_in        (pc_in),
        .flush        (flush),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .hazard       (hazard),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_opcode    (id_opcode),
        .id_rd        (id_rd),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_imm       (id_imm),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_mem_write (id_mem_write),
        .id_branch    (id_branch),
        .id_halt      (id_halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [15:0] imm;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        hl;
    } vec_t;

    vec_t vecs [16];
    vec_t rec;

    function automatic logic [77:0] snap();
        return {id_valid, id_pc, id_opcode, id_rd, id_rs_data, id_rt_data, id_imm,
                id_reg_write, id_mem_read, id_mem_write, id_branch, id_halt};
    endfunction

    function automatic logic [77:0] expect_of(input vec_t v);
        return {1'b1, v.pc, v.op, v.rd, v.rs, v.rt, v.imm, v.rw, v.mr, v.mw, v.br, v.hl};
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            instr     pc        op    rd    rs        rt        imm       rw mr mw br hl
        vecs[0]  = '{16'h0534, 16'h0100, 4'h0, 4'h5, 16'h1234, 16'h5678, 16'h0000, 1, 0, 0, 0, 0};
        vecs[1]  = '{16'h0012, 16'h0102, 4'h0, 4'h0, 16'h0011, 16'h0022, 16'h0000, 0, 0, 0, 0, 0};
        vecs[2]  = '{16'h823F, 16'h0104, 4'h8, 4'h2, 16'h1234, 16'h0000, 16'hFFFF, 1, 1, 0, 0, 0};
        vecs[3]  = '{16'h8347, 16'h0106, 4'h8, 4'h3, 16'h5678, 16'h0000, 16'h0007, 1, 1, 0, 0, 0};
        vecs[4]  = '{16'h9347, 16'h0108, 4'h9, 4'h3, 16'h5678, 16'h1234, 16'h0007, 0, 0, 1, 0, 0};
        vecs[5]  = '{16'h9218, 16'h010A, 4'h9, 4'h2, 16'h0011, 16'h0022, 16'hFFF8, 0, 0, 1, 0, 0};
        vecs[6]  = '{16'hB180, 16'h010C, 4'hB, 4'h1, 16'h0011, 16'h0000, 16'h0080, 1, 0, 0, 0, 0};
        vecs[7]  = '{16'hA4FF, 16'h010E, 4'hA, 4'h4, 16'h5678, 16'h0000, 16'h00FF, 1, 0, 0, 0, 0};
        vecs[8]  = '{16'hD800, 16'h0110, 4'hD, 4'hF, 16'h0000, 16'h0000, 16'hF800, 1, 0, 0, 1, 0};
        vecs[9]  = '{16'hD7FF, 16'h0112, 4'hD, 4'hF, 16'h0000, 16'h0000, 16'h07FF, 1, 0, 0, 1, 0};
        vecs[10] = '{16'hC0A5, 16'h0114, 4'hC, 4'h0, 16'h0000, 16'h0000, 16'h00A5, 0, 0, 0, 1, 0};
        vecs[11] = '{16'hC3FF, 16'h0116, 4'hC, 4'h3, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 0, 1, 0};
        vecs[12] = '{16'hE000, 16'h0118, 4'hE, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 0};
        vecs[13] = '{16'h7123, 16'h011A, 4'h7, 4'h1, 16'h0022, 16'h1234, 16'h0000, 1, 0, 0, 0, 0};
        vecs[14] = '{16'hB080, 16'h011C, 4'hB, 4'h0, 16'h0000, 16'h0000, 16'h0080, 0, 0, 0, 0, 0};
        vecs[15] = '{16'h0900, 16'h011E, 4'h0, 4'h9, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 0};

        rst      = 1'b0;
        instr_in = FILLER;
        pc_in    = 16'h0000;
        flush    = 1'b0;
        wb_en    = 1'b0;
        wb_addr  = 4'd0;
        wb_data  = 16'h0000;

        // Reset state
        step();
        step();
        check("reset_outputs", snap(), '0);
        check("reset_hazard", hazard, 1'b0);
        rst = 1'b1;

        // Register writes (including an ignored write to R0)
        wb_en = 1'b1;
        wb_addr = 4'd1; wb_data = 16'h0011; step();
        wb_addr = 4'd2; wb_data = 16'h0022; step();
        wb_addr = 4'd3; wb_data = 16'h1234; step();
        wb_addr = 4'd4; wb_data = 16'h5678; step();
        wb_addr = 4'd0; wb_data = 16'hFFFF; step();
        wb_en = 1'b0;

        // Decode table: vector enters IF/ID, filler follows, check ID/EX
        for (int i = 0; i < 16; i++) begin
            instr_in = vecs[i].instr;
            pc_in    = vecs[i].pc;
            step();
            instr_in = FILLER;
            pc_in    = 16'h0FFE;
            step();
            check($sformatf("decode_vec%0d_%h", i, vecs[i].instr), snap(), expect_of(vecs[i]));
        end

        // Load-use: LW R2 then ADD R6,R2,R1
        instr_in = 16'h8210; pc_in = 16'h0140; step();
        instr_in = 16'h0621; pc_in = 16'h0142; step();
        check("lu_hazard_on", hazard, 1'b1);
        check("lu_lw_issued", {id_valid, id_mem_read, id_rd}, {1'b1, 1'b1, 4'd2});
        instr_in = FILLER; pc_in = 16'h0144; step();
        check("lu_bubble", id_valid, 1'b0);
        check("lu_hazard_off", hazard, 1'b0);
        step();
        check("lu_add_issued", {id_valid, id_pc, id_rd, id_rs_data, id_rt_data, id_reg_write},
              {1'b1, 16'h0142, 4'd6, 16'h0022, 16'h0011, 1'b1});

        // Flush with a valid SW in IF/ID
        instr_in = 16'h9347; pc_in = 16'h0150; step();
        instr_in = FILLER; flush = 1'b1; #1;
        check("flush_hazard", hazard, 1'b0);
        step();
        flush = 1'b0;
        check("flush_sw_squashed", {id_valid, id_mem_write}, 2'b00);
        step();
        check("flush_ifid_cleared", id_valid, 1'b0);

        // Flush during a load-use stall
        instr_in = 16'h8210; pc_in = 16'h0160; step();
        instr_in = 16'h0621; pc_in = 16'h0162; step();
        check("flu_hazard_before", hazard, 1'b1);
        flush = 1'b1; #1;
        check("flu_hazard_flushed", hazard, 1'b0);
        step();
        flush = 1'b0;
        instr_in = FILLER; pc_in = 16'h0164;
        check("flu_idex_cleared", id_valid, 1'b0);
        step();
        check("flu_add_squashed", id_valid, 1'b0);
        step();
        check("flu_resume", {id_valid, id_pc, id_branch, hazard}, {1'b1, 16'h0164, 1'b1, 1'b0});

        // Write-back and read of R7 in the same cycle
        instr_in = 16'h0870; pc_in = 16'h0170; step();
        instr_in = FILLER; pc_in = 16'h0172;
        wb_en = 1'b1; wb_addr = 4'd7; wb_data = 16'hBEEF; #1;
`ifdef WB_BYPASS_EN
        check("wb_bypass_no_stall", hazard, 1'b0);
        step();
        wb_en = 1'b0;
        check("wb_bypass_data", {id_valid, id_rs_data}, {1'b1, 16'hBEEF});
`else
        check("wb_stall_hazard", hazard, 1'b1);
        step();
        wb_en = 1'b0; #1;
        check("wb_stall_bubble", {id_valid, hazard}, 2'b00);
        step();
        check("wb_stall_data", {id_valid, id_rs_data}, {1'b1, 16'hBEEF});
`endif

        // Halt, then asynchronous reset while halted
        instr_in = 16'hF000; pc_in = 16'h0180; step();
        instr_in = FILLER; pc_in = 16'h0182; step();
        check("halt_issued", {id_valid, id_halt}, 2'b11);
        check("halt_hazard_0", hazard, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            step();
            check($sformatf("halt_hazard_%0d", c), hazard, 1'b1);
        end
        check("halt_bubbles", {id_valid, id_halt}, 2'b00);
        #2;
        rst = 1'b0;
        #1;
        check("halt_reset_hazard", hazard, 1'b0);
        check("halt_reset_outputs", snap(), '0);
        step();
        rst = 1'b1;

        // After reset: register file cleared, decode resumes
        instr_in = 16'h0534; pc_in = 16'h0400; step();
        instr_in = FILLER; pc_in = 16'h0402; step();
        rec = '{16'h0534, 16'h0400, 4'h0, 4'h5, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 0};
        check("post_reset_add", snap(), expect_of(rec));
        check("post_reset_hazard", hazard, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
